datapath_ctrl_sequencer: RTL and testbench

//  Synthesizable replay engine for the control inputs of core_datapath.

---
 rtl/datapath_ctrl_sequencer.sv | 177 +++++++++++++++++
 tb/tb_datapath_ctrl_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_ctrl_sequencer.sv
// Replay engine for core_datapath control inputs: pulses the datapath reset, steps through a
// programmed table of control words and counts PC mismatches against per-step expected values.
module datapath_ctrl_sequencer #(
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned RST_CYCLES = 1,
  parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [12:0]       cfg_ctrl,
  input  logic [XLEN-1:0]   cfg_exp_pc,
  input  logic              cfg_chk,
  input  logic              start,
  input  logic [ADDR_W:0]   num_steps,
  input  logic              abort,
  input  logic [XLEN-1:0]   dp_pc,
  output logic              dp_reset,
  output logic [1:0]        PCSrc,
  output logic [1:0]        ResultSrc,
  output logic [2:0]        ImmSrc,
  output logic              RegWrite,
  output logic              ALUSrc,
  output logic              MemWrite,
  output logic [2:0]        ALUControl,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] first_err_step
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDutRst = 2'd1;
  localparam logic [1:0] StRun    = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  localparam int unsigned RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0]  RstLast = RCW'(RST_CYCLES - 1);
  localparam logic [ADDR_W:0] DepthW  = (ADDR_W + 1)'(DEPTH);

  // Program table; deliberately not reset so it survives a sequencer reset.
  logic [12:0]      tbl_ctrl_q [DEPTH];
  logic [XLEN-1:0]  tbl_exp_q  [DEPTH];
  logic [DEPTH-1:0] tbl_chk_q;

  logic [1:0]        state_q, state_d;
  logic [RCW-1:0]    rst_cnt_q, rst_cnt_d;
  logic [ADDR_W-1:0] step_q, step_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [7:0]        err_count_q, err_count_d;
  logic [ADDR_W-1:0] first_err_q, first_err_d;
  logic              pass_q, pass_d;

  logic              tbl_we;
  logic [ADDR_W:0]   steps_clamped;
  logic [ADDR_W:0]   steps_m1;
  logic              step_mismatch;
  logic [7:0]        err_count_inc;
  logic [12:0]       ctrl_word;

  assign busy   = (state_q == StDutRst) || (state_q == StRun);
  assign tbl_we = cfg_we && !busy;

  always_ff @(posedge clk) begin
    if (tbl_we) begin
      tbl_ctrl_q[cfg_addr] <= cfg_ctrl;
      tbl_exp_q[cfg_addr]  <= cfg_exp_pc;
      tbl_chk_q[cfg_addr]  <= cfg_chk;
    end
  end

  always_comb begin
    steps_clamped = (num_steps > DepthW) ? DepthW : num_steps;
    steps_m1      = steps_clamped - (ADDR_W + 1)'(1);
    step_mismatch = (state_q == StRun) && tbl_chk_q[step_q] && (dp_pc != tbl_exp_q[step_q]);
    err_count_inc = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;
  end

  always_comb begin
    state_d     = state_q;
    rst_cnt_d   = rst_cnt_q;
    step_d      = step_q;
    last_d      = last_q;
    err_count_d = err_count_q;
    first_err_d = first_err_q;
    pass_d      = pass_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (num_steps == '0) begin
            state_d = StDone;
            pass_d  = 1'b1;
          end else begin
            state_d     = StDutRst;
            rst_cnt_d   = '0;
            err_count_d = '0;
            first_err_d = '0;
            pass_d      = 1'b0;
            last_d      = steps_m1[ADDR_W-1:0];
          end
        end
      end
      StDutRst: begin
        if (rst_cnt_q == RstLast) begin
          state_d = StRun;
          step_d  = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RCW'(1);
        end
      end
      StRun: begin
        if (step_mismatch) begin
          err_count_d = err_count_inc;
          if (err_count_q == 8'd0) begin
            first_err_d = step_q;
          end
        end
        // Pass must include the mismatch (if any) of the final step.
        if (step_q == last_q) begin
          state_d = StDone;
          pass_d  = (err_count_d == 8'd0);
        end else begin
          step_d = step_q + ADDR_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      pass_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rst_cnt_q   <= '0;
      step_q      <= '0;
      last_q      <= '0;
      err_count_q <= '0;
      first_err_q <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      step_q      <= step_d;
      last_q      <= last_d;
      err_count_q <= err_count_d;
      first_err_q <= first_err_d;
      pass_q      <= pass_d;
    end
  end

  // Outside RUN the datapath sees the all-zero safe word (no register or memory writes).
  always_comb begin
    ctrl_word = (state_q == StRun) ? tbl_ctrl_q[step_q] : '0;
  end

  assign {PCSrc, ResultSrc, ImmSrc, RegWrite, ALUSrc, MemWrite, ALUControl} = ctrl_word;

  assign dp_reset       = (state_q != StRun);
  assign done           = (state_q == StDone);
  assign pass           = pass_q;
  assign err_count      = err_count_q;
  assign first_err_step = first_err_q;

endmodule

// File: tb/tb_datapath_ctrl_sequencer.sv
// Bench for datapath_ctrl_sequencer: a simple PC model stands in for core_datapath, and each
// run is checked cycle by cycle against expectations derived from the programmed table.
module tb_datapath_ctrl_sequencer;

  localparam int unsigned DEPTH      = 8;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned RST_CYCLES = 2;
  localparam int unsigned ADDR_W     = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              reset;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [12:0]       cfg_ctrl;
  logic [XLEN-1:0]   cfg_exp_pc;
  logic              cfg_chk;
  logic              start;
  logic [ADDR_W:0]   num_steps;
  logic              abort;
  logic [XLEN-1:0]   dp_pc;
  logic              dp_reset;
  logic [1:0]        PCSrc;
  logic [1:0]        ResultSrc;
  logic [2:0]        ImmSrc;
  logic              RegWrite;
  logic              ALUSrc;
  logic              MemWrite;
  logic [2:0]        ALUControl;
  logic              busy;
  logic              done;
  logic              pass;
  logic [7:0]        err_count;
  logic [ADDR_W-1:0] first_err_step;

  logic [12:0]     ctrl_obs;
  logic [12:0]     tbl_ctrl [DEPTH];
  logic [XLEN-1:0] tbl_exp  [DEPTH];
  logic            tbl_chk  [DEPTH];
  logic [XLEN-1:0] jump_tgt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign ctrl_obs = {PCSrc, ResultSrc, ImmSrc, RegWrite, ALUSrc, MemWrite, ALUControl};

  // Stand-in datapath PC: cleared under reset, jumps on any PCSrc, otherwise advances by 4.
  always @(posedge clk) begin
    if (dp_reset === 1'b1) dp_pc <= '0;
    else if (PCSrc != 2'b00) dp_pc <= jump_tgt;
    else dp_pc <= dp_pc + 32'd4;
  end

  datapath_ctrl_sequencer #(
    .DEPTH     (DEPTH),
    .XLEN      (XLEN),
    .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_we        (cfg_we),
    .cfg_addr      (cfg_addr),
    .cfg_ctrl      (cfg_ctrl),
    .cfg_exp_pc    (cfg_exp_pc),
    .cfg_chk       (cfg_chk),
    .start         (start),
    .num_steps     (num_steps),
    .abort         (abort),
    .dp_pc         (dp_pc),
    .dp_reset      (dp_reset),
    .PCSrc         (PCSrc),
    .ResultSrc     (ResultSrc),
    .ImmSrc        (ImmSrc),
    .RegWrite      (RegWrite),
    .ALUSrc        (ALUSrc),
    .MemWrite      (MemWrite),
    .ALUControl    (ALUControl),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_count     (err_count),
    .first_err_step(first_err_step)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int a, input logic [12:0] c, input logic [XLEN-1:0] e,
                             input logic k);
    cfg_we     = 1'b1;
    cfg_addr   = a[ADDR_W-1:0];
    cfg_ctrl   = c;
    cfg_exp_pc = e;
    cfg_chk    = k;
    tbl_ctrl[a] = c;
    tbl_exp[a]  = e;
    tbl_chk[a]  = k;
    tick();
    cfg_we = 1'b0;
  endtask

  // Starts a run of n steps and checks every cycle until the sequencer is idle again.
  task automatic test_program_run(input string name, input int n);
    int n_eff;
    int errs;
    int first;
    logic [XLEN-1:0] pc;
    n_eff = (n > int'(DEPTH)) ? int'(DEPTH) : n;
    errs  = 0;
    first = 0;
    pc    = '0;
    for (int k = 0; k < n_eff; k++) begin
      if (tbl_chk[k] && (pc != tbl_exp[k])) begin
        if (errs == 0) first = k;
        errs = (errs < 255) ? errs + 1 : 255;
      end
      pc = (tbl_ctrl[k][12:11] != 2'b00) ? jump_tgt : pc + 32'd4;
    end

    start     = 1'b1;
    num_steps = n[ADDR_W:0];
    tick();
    start  = 1'b0;
    cfg_we = 1'b0;
    for (int c = 0; c < int'(RST_CYCLES); c++) begin
      checks++;
      if (dp_reset !== 1'b1 || busy !== 1'b1 || ctrl_obs !== 13'h0 || done !== 1'b0) begin
        failures++;
        $display("FAIL %s dut_rst c=%0d: dp_reset=%b busy=%b ctrl=%h done=%b, need 1 1 0000 0",
                 name, c, dp_reset, busy, ctrl_obs, done);
      end
      tick();
    end
    for (int k = 0; k < n_eff; k++) begin
      checks++;
      if (dp_reset !== 1'b0 || busy !== 1'b1 || ctrl_obs !== tbl_ctrl[k] || done !== 1'b0) begin
        failures++;
        $display("FAIL %s run k=%0d: dp_reset=%b busy=%b ctrl=%h done=%b, need 0 1 %h 0",
                 name, k, dp_reset, busy, ctrl_obs, done, tbl_ctrl[k]);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || dp_reset !== 1'b1 || ctrl_obs !== 13'h0 ||
        pass !== (errs == 0) || err_count !== errs[7:0] ||
        first_err_step !== first[ADDR_W-1:0]) begin
      failures++;
      $display("FAIL %s done: done=%b busy=%b dp_reset=%b ctrl=%h pass=%b err=%0d first=%0d, need 1 0 1 0000 %b %0d %0d",
               name, done, busy, dp_reset, ctrl_obs, pass, err_count, first_err_step,
               (errs == 0), errs, first);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || pass !== (errs == 0)) begin
      failures++;
      $display("FAIL %s after_done: done=%b busy=%b pass=%b, need 0 0 %b",
               name, done, busy, pass, (errs == 0));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (dp_reset !== 1'b1 || ctrl_obs !== 13'h0 || busy !== 1'b0 || done !== 1'b0 ||
        pass !== 1'b0 || err_count !== 8'd0 || first_err_step !== '0) begin
      failures++;
      $display("FAIL reset: dp_reset=%b ctrl=%h busy=%b done=%b pass=%b err=%0d first=%0d, need 1 0000 0 0 0 0 0",
               dp_reset, ctrl_obs, busy, done, pass, err_count, first_err_step);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (dp_reset !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: dp_reset=%b busy=%b done=%b, need 1 0 0", dp_reset, busy, done);
    end
  endtask

  task automatic test_basic();
    write_entry(0, 13'h0123, 32'h0, 1'b1);
    write_entry(1, 13'h04B5, 32'h4, 1'b1);
    write_entry(2, 13'h02DA, 32'h8, 1'b1);
    test_program_run("basic", 3);
  endtask

  task automatic test_jump();
    jump_tgt = 32'h38;
    write_entry(1, {2'b10, 2'b00, 3'b000, 1'b0, 1'b1, 1'b0, 3'b000}, 32'h4, 1'b1);
    write_entry(2, 13'h02DA, 32'h38, 1'b1);
    test_program_run("jump", 3);
  endtask

  task automatic test_mismatch();
    write_entry(1, 13'h04B5, 32'h4, 1'b1);
    write_entry(2, 13'h02DA, 32'hC, 1'b1);
    test_program_run("mismatch", 3);
  endtask

  task automatic test_abort();
    write_entry(2, 13'h02DA, 32'h8, 1'b1);
    write_entry(3, 13'h0111, 32'hC, 1'b1);
    write_entry(4, 13'h0222, 32'h10, 1'b1);
    start     = 1'b1;
    num_steps = 4'd5;
    tick();
    start = 1'b0;
    repeat (RST_CYCLES + 1) tick();
    checks++;
    if (busy !== 1'b1 || dp_reset !== 1'b0 || ctrl_obs !== tbl_ctrl[1]) begin
      failures++;
      $display("FAIL abort_step1: busy=%b dp_reset=%b ctrl=%h, need 1 0 %h",
               busy, dp_reset, ctrl_obs, tbl_ctrl[1]);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || dp_reset !== 1'b1 || ctrl_obs !== 13'h0 || done !== 1'b0 ||
        pass !== 1'b0) begin
      failures++;
      $display("FAIL abort: busy=%b dp_reset=%b ctrl=%h done=%b pass=%b, need 0 1 0000 0 0",
               busy, dp_reset, ctrl_obs, done, pass);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL abort_quiet c=%0d: done=%b busy=%b, need 0 0", c, done, busy);
      end
    end
  endtask

  task automatic test_zero_steps();
    start     = 1'b1;
    num_steps = '0;
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0 || dp_reset !== 1'b1 ||
        ctrl_obs !== 13'h0) begin
      failures++;
      $display("FAIL zero_steps: done=%b pass=%b busy=%b dp_reset=%b ctrl=%h, need 1 1 0 1 0000",
               done, pass, busy, dp_reset, ctrl_obs);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || pass !== 1'b1) begin
      failures++;
      $display("FAIL zero_steps_after: done=%b busy=%b pass=%b, need 0 0 1", done, busy, pass);
    end
  endtask

  task automatic test_clamp();
    for (int k = 0; k < int'(DEPTH); k++) begin
      logic [31:0] r;
      r = $urandom;
      write_entry(k, {2'b00, r[10:0]}, 32'(k * 4), r[16]);
    end
    test_program_run("clamp", int'(DEPTH) + 5);
  endtask

  task automatic test_write_start();
    cfg_we     = 1'b1;
    cfg_addr   = '0;
    cfg_ctrl   = 13'h0555;
    cfg_exp_pc = 32'h0;
    cfg_chk    = 1'b1;
    tbl_ctrl[0] = 13'h0555;
    tbl_exp[0]  = 32'h0;
    tbl_chk[0]  = 1'b1;
    test_program_run("write_start", 2);
  endtask

  task automatic test_busy_inputs_and_reset();
    write_entry(0, 13'h0555, 32'hDEAD, 1'b1);
    start     = 1'b1;
    num_steps = (ADDR_W + 1)'(DEPTH);
    tick();
    start = 1'b0;
    repeat (RST_CYCLES + 2) tick();
    // Now in step 2: try to restart and overwrite entry 5 while busy.
    start      = 1'b1;
    num_steps  = 4'd1;
    cfg_we     = 1'b1;
    cfg_addr   = 3'd5;
    cfg_ctrl   = ~tbl_ctrl[5];
    cfg_exp_pc = ~tbl_exp[5];
    cfg_chk    = ~tbl_chk[5];
    tick();
    start  = 1'b0;
    cfg_we = 1'b0;
    checks++;
    if (busy !== 1'b1 || dp_reset !== 1'b0 || ctrl_obs !== tbl_ctrl[3] || err_count !== 8'd1) begin
      failures++;
      $display("FAIL busy_ignore: busy=%b dp_reset=%b ctrl=%h err=%0d, need 1 0 %h 1",
               busy, dp_reset, ctrl_obs, err_count, tbl_ctrl[3]);
    end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (dp_reset !== 1'b1 || ctrl_obs !== 13'h0 || busy !== 1'b0 || done !== 1'b0 ||
        pass !== 1'b0 || err_count !== 8'd0 || first_err_step !== '0) begin
      failures++;
      $display("FAIL mid_run_reset: dp_reset=%b ctrl=%h busy=%b done=%b pass=%b err=%0d first=%0d, need 1 0000 0 0 0 0 0",
               dp_reset, ctrl_obs, busy, done, pass, err_count, first_err_step);
    end
    tick();
    test_program_run("after_reset", int'(DEPTH));
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      logic [XLEN-1:0] pc;
      jump_tgt = $urandom & 32'hFFFF_FFFC;
      pc = '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        logic [31:0] r;
        logic [12:0] c;
        logic [XLEN-1:0] e;
        r = $urandom;
        c = r[12:0];
        if (r[15:13] != 3'b000) c[12:11] = 2'b00;
        e = (r[19:18] == 2'b00) ? (pc ^ 32'h10) : pc;
        write_entry(k, c, e, r[20]);
        pc = (c[12:11] != 2'b00) ? jump_tgt : pc + 32'd4;
      end
      test_program_run($sformatf("random%0d", it), int'($urandom_range(1, 2 * DEPTH - 1)));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, need completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    cfg_we     = 1'b0;
    cfg_addr   = '0;
    cfg_ctrl   = '0;
    cfg_exp_pc = '0;
    cfg_chk    = 1'b0;
    start      = 1'b0;
    num_steps  = '0;
    abort      = 1'b0;
    jump_tgt   = 32'h38;
    for (int k = 0; k < int'(DEPTH); k++) begin
      tbl_ctrl[k] = '0;
      tbl_exp[k]  = '0;
      tbl_chk[k]  = 1'b0;
    end
    test_reset();
    test_basic();
    test_jump();
    test_mismatch();
    test_abort();
    test_zero_steps();
    test_clamp();
    test_write_start();
    test_busy_inputs_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
